// File: rtl/basket_register_if.sv
// rtl/basket_register_if.sv - button/basket bus between sale-terminal logic and basket_register
//
// Purpose: carries the three button levels and the product ID into the
// basket register, and the published basket and status flags back out.
// Ports (signals):
//   add_btn, remove_btn, clear_btn : button levels (async, debounced)
//   product_id                     : ID to add, ID_W bits, 0 = empty
//   product_IDS                    : published basket, SLOTS*ID_W bits
//   basket_count                   : non-empty slots in published basket
//   basket_full, basket_empty      : working-basket occupancy flags
//   update_pending                 : working basket not yet published
//   op_error                       : one-cycle pulse on a rejected request
// Modports: master = button/terminal side, slave = basket_register.

interface basket_register_if #(
  parameter int SLOTS = 12,
  parameter int ID_W  = 4
) ();
  logic                  add_btn;
  logic                  remove_btn;
  logic                  clear_btn;
  logic [ID_W-1:0]       product_id;
  logic [SLOTS*ID_W-1:0] product_IDS;
  logic [3:0]            basket_count;
  logic                  basket_full;
  logic                  basket_empty;
  logic                  update_pending;
  logic                  op_error;

  modport master (
    output add_btn, remove_btn, clear_btn, product_id,
    input  product_IDS, basket_count, basket_full, basket_empty,
           update_pending, op_error
  );

  modport slave (
    input  add_btn, remove_btn, clear_btn, product_id,
    output product_IDS, basket_count, basket_full, basket_empty,
           update_pending, op_error
  );
endinterface

// File: rtl/basket_register.sv
// rtl/basket_register.sv - working/published product basket fed by add/remove/clear buttons
//
// Purpose: keeps a dense, left-packed working basket edited by button
// presses and copies it to the display-facing product_IDS once per frame
// on a fixed blanking line, so the renderer never sees a mid-frame change.
// Ports:
//   CLK, RST      : clock and synchronous active-high reset
//   H_counter     : 11-bit horizontal pixel counter
//   V_counter     : 10-bit vertical line counter
//   bus (slave)   : buttons and product_id in; published basket and
//                   status flags out (see basket_register_if)

module basket_register #(
  parameter int SLOTS        = 12,
  parameter int ID_W         = 4,
  parameter int PUBLISH_LINE = 600
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [10:0]         H_counter,
  input  logic [9:0]          V_counter,
  basket_register_if.slave    bus
);
  localparam int W  = SLOTS * ID_W;
  localparam int CW = 4;

  // Button vector order: {clear, remove, add}
  logic [2:0]      btn_s1_q, btn_s1_d;
  logic [2:0]      btn_s2_q, btn_s2_d;
  logic [2:0]      btn_prev_q, btn_prev_d;
  logic [ID_W-1:0] id_s1_q, id_s1_d;
  logic [ID_W-1:0] id_s2_q, id_s2_d;

  logic [W-1:0]    work_q, work_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    pub_q, pub_d;
  logic [CW-1:0]   pub_count_q, pub_count_d;
  logic            dirty_q, dirty_d;
  logic            err_q, err_d;

  logic [2:0]      req;
  logic            publish;

  always_comb begin
    btn_s1_d   = {bus.clear_btn, bus.remove_btn, bus.add_btn};
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    id_s1_d    = bus.product_id;
    id_s2_d    = id_s1_q;

    req     = btn_s2_q & ~btn_prev_q;
    publish = (V_counter == 10'(PUBLISH_LINE)) && (H_counter == 11'd0);

    work_d      = work_q;
    count_d     = count_q;
    pub_d       = pub_q;
    pub_count_d = pub_count_q;
    dirty_d     = dirty_q;
    err_d       = 1'b0;

    // Publish samples the pre-update basket; a same-cycle edit below then
    // overrides the dirty clear so the edit is not lost.
    if (publish) begin
      pub_d       = work_q;
      pub_count_d = count_q;
      dirty_d     = 1'b0;
    end

    if (req[2]) begin
      work_d  = '0;
      count_d = '0;
      dirty_d = 1'b1;
    end else if (req[1]) begin
      if (count_q != '0) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (CW'(k + 1) == count_q) work_d[W-1-ID_W*k -: ID_W] = '0;
        end
        count_d = count_q - 1'b1;
        dirty_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (req[0]) begin
      if ((count_q != CW'(SLOTS)) && (id_s2_q != '0)) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (CW'(k) == count_q) work_d[W-1-ID_W*k -: ID_W] = id_s2_q;
        end
        count_d = count_q + 1'b1;
        dirty_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_s1_q    <= '0;
      btn_s2_q    <= '0;
      btn_prev_q  <= '0;
      id_s1_q     <= '0;
      id_s2_q     <= '0;
      work_q      <= '0;
      count_q     <= '0;
      pub_q       <= '0;
      pub_count_q <= '0;
      dirty_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      btn_s1_q    <= btn_s1_d;
      btn_s2_q    <= btn_s2_d;
      btn_prev_q  <= btn_prev_d;
      id_s1_q     <= id_s1_d;
      id_s2_q     <= id_s2_d;
      work_q      <= work_d;
      count_q     <= count_d;
      pub_q       <= pub_d;
      pub_count_q <= pub_count_d;
      dirty_q     <= dirty_d;
      err_q       <= err_d;
    end
  end

  assign bus.product_IDS    = pub_q;
  assign bus.basket_count   = pub_count_q;
  assign bus.basket_full    = (count_q == CW'(SLOTS));
  assign bus.basket_empty   = (count_q == '0);
  assign bus.update_pending = dirty_q;
  assign bus.op_error       = err_q;
endmodule
